// File: rtl/matrix_key_scan_pkg.sv
// Shared game keypad definitions: debounce states, game key codes and
// default timing constants for the 50 MHz keypad scanner.
package matrix_key_scan_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_DEB,
    PRESSED,
    RELEASE_DEB
  } key_state_e;

  localparam logic [3:0] KEY_START = 4'd0;
  localparam logic [3:0] KEY_UP    = 4'd1;
  localparam logic [3:0] KEY_LEFT  = 4'd4;
  localparam logic [3:0] KEY_RIGHT = 4'd6;
  localparam logic [3:0] KEY_DOWN  = 4'd9;

  // 1 ms row slot at 50 MHz
  localparam int SCAN_CYCLES_DEF    = 50000;
  localparam int DEBOUNCE_SCANS_DEF = 8;
  localparam int REPEAT_SCANS_DEF   = 250;

  function automatic logic [3:0] key_code_of(
    input logic [1:0] row,
    input logic [1:0] col
  );
    return {row, col};
  endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// Frame-level debounce of the keypad candidate; emits press events.
// Ports: Clk_50mhz, Rst (sync, high), Eval strobe, Cand/Cand_valid in;
// Key_code, Key_valid (1-cycle pulse), Key_held out.
// KEY_REPEAT_EN adds auto-repeat every REPEAT_SCANS frames while held.
module key_debounce_fsm
  import matrix_key_scan_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF,
  parameter int REPEAT_SCANS   = REPEAT_SCANS_DEF
) (
  input  logic       Clk_50mhz,
  input  logic       Rst,
  input  logic       Eval,
  input  logic       Cand_valid,
  input  logic [3:0] Cand,
  output logic [3:0] Key_code,
  output logic       Key_valid,
  output logic       Key_held
);

  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 255) begin : g_bad_deb
    $error("DEBOUNCE_SCANS must be 1..255");
  end
  if (REPEAT_SCANS < 1) begin : g_bad_rpt
    $error("REPEAT_SCANS must be at least 1");
  end

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_SCANS);
  localparam bit DEB_ONE = (DEBOUNCE_SCANS == 1);

  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_q, key_d;
  logic          same;
  logic          fire;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);
  localparam logic [RW-1:0] RPT_M1 = RW'(REPEAT_SCANS - 1);
  logic [RW-1:0] rpt_q, rpt_d;
`endif

  assign same = Cand_valid && (Cand == key_q);

  always_ff @(posedge Clk_50mhz) begin
    if (Rst) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      key_q     <= '0;
      Key_code  <= '0;
      Key_valid <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_q     <= key_d;
      Key_valid <= fire;
      if (fire) Key_code <= key_d;
`ifdef KEY_REPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    if (Eval) begin
      unique case (state_q)
        RELEASED: begin
          if (Cand_valid) begin
            key_d   = Cand;
            cnt_d   = CW'(1);
            state_d = DEB_ONE ? PRESSED : PRESS_DEB;
          end
        end
        PRESS_DEB: begin
          if (!Cand_valid) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (same) begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == DEB_LAST) state_d = PRESSED;
          end else begin
            key_d = Cand;
            cnt_d = CW'(1);
          end
        end
        PRESSED: begin
          if (!same) begin
            cnt_d   = CW'(1);
            state_d = DEB_ONE ? RELEASED : RELEASE_DEB;
          end
        end
        RELEASE_DEB: begin
          if (same) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == DEB_LAST) state_d = RELEASED;
          end
        end
        default: state_d = RELEASED;
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  // Counts only while staying PRESSED; wraps when a repeat fires.
  always_comb begin
    rpt_d = rpt_q;
    if (Eval) begin
      if (state_q == PRESSED && state_d == PRESSED && rpt_q != RPT_M1)
        rpt_d = rpt_q + RW'(1);
      else
        rpt_d = '0;
    end
  end
`endif

  always_comb begin
    fire     = 1'b0;
    Key_held = (state_q == PRESSED) || (state_q == RELEASE_DEB);
    if (Eval && state_d == PRESSED) begin
      // Returning from RELEASE_DEB is the same press: no new event.
      if (state_q == RELEASED || state_q == PRESS_DEB) fire = 1'b1;
`ifdef KEY_REPEAT_EN
      if (state_q == PRESSED && rpt_q == RPT_M1) fire = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/matrix_key_scan.sv
// 4x4 active-low keypad scanner: row drive, column sync, frame evaluation.
// Ports: Clk_50mhz, Rst (sync, high), Key_col in; Key_row, Key_code,
// Key_valid, Key_held out. Optional auto-repeat via KEY_REPEAT_EN.
module matrix_key_scan
  import matrix_key_scan_pkg::*;
#(
  parameter int SCAN_CYCLES    = SCAN_CYCLES_DEF,
  parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEF,
  parameter int REPEAT_SCANS   = REPEAT_SCANS_DEF
) (
  input  logic       Clk_50mhz,
  input  logic       Rst,
  input  logic [3:0] Key_col,
  output logic [3:0] Key_row,
  output logic [3:0] Key_code,
  output logic       Key_valid,
  output logic       Key_held
);

  if (SCAN_CYCLES < 4) begin : g_bad_scan
    $error("SCAN_CYCLES must be at least 4");
  end

  localparam int SW = $clog2(SCAN_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_CYCLES - 1);

  logic [3:0]    col_meta, col_sync;
  logic [SW-1:0] slot_q;
  logic [1:0]    row_q;
  logic [3:0]    frame_q [4];
  logic          eval_q;
  logic          slot_end;
  logic [4:0]    n_low;
  logic [3:0]    cand;
  logic          cand_valid;

  assign slot_end = (slot_q == SLOT_LAST);
  assign Key_row  = ~(4'b0001 << row_q);

  always_ff @(posedge Clk_50mhz) begin
    if (Rst) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
      slot_q   <= '0;
      row_q    <= '0;
      eval_q   <= 1'b0;
      for (int r = 0; r < 4; r++) frame_q[r] <= 4'hF;
    end else begin
      col_meta <= Key_col;
      col_sync <= col_meta;
      // EVAL is the cycle right after the row-3 sample lands.
      eval_q   <= slot_end && (row_q == 2'd3);
      if (slot_end) begin
        slot_q         <= '0;
        frame_q[row_q] <= col_sync;
        row_q          <= row_q + 2'd1;
      end else begin
        slot_q <= slot_q + SW'(1);
      end
    end
  end

  // Exactly one low bit in the frame is a key; more is ghosting.
  always_comb begin
    n_low = '0;
    cand  = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!frame_q[r][c]) begin
          n_low = n_low + 5'd1;
          cand  = key_code_of(2'(r), 2'(c));
        end
      end
    end
    cand_valid = (n_low == 5'd1);
  end

  key_debounce_fsm #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .REPEAT_SCANS  (REPEAT_SCANS)
  ) u_deb (
    .Clk_50mhz (Clk_50mhz),
    .Rst       (Rst),
    .Eval      (eval_q),
    .Cand_valid(cand_valid),
    .Cand      (cand),
    .Key_code  (Key_code),
    .Key_valid (Key_valid),
    .Key_held  (Key_held)
  );

endmodule

// File: tb/tb_matrix_key_scan.sv
// Bench for matrix_key_scan: keypad model, frame-level reference model,
// directed timing pins and randomized key traffic.
module tb_matrix_key_scan;
  import matrix_key_scan_pkg::*;

  localparam int SC  = 4;
  localparam int DEB = 3;
  localparam int REP = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mask = '0;
  logic [3:0]  key_col;
  logic [3:0]  key_row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  int n_pass = 0;
  int n_chk  = 0;
  int n      = 0;
  bit chk_en = 1'b0;

  always #10 clk = ~clk;

  // Physical keypad: a pressed key shorts its row line to its column.
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!key_row[r] && mask[r*4+c]) key_col[c] = 1'b0;
  end

  matrix_key_scan #(
    .SCAN_CYCLES   (SC),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS  (REP)
  ) dut (
    .Clk_50mhz(clk),
    .Rst      (rst),
    .Key_col  (key_col),
    .Key_row  (key_row),
    .Key_code (key_code),
    .Key_valid(key_valid),
    .Key_held (key_held)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int         k;
  logic [3:0] h1, h2, colnow, sample;
  logic [3:0] frm [4];
  bit         held;
  int         hkey, run_key, run_len, miss, hit;
  logic [3:0] exp_row, exp_code;
  logic       exp_valid, exp_held;

  function automatic logic [3:0] cols_of(input logic [15:0] m,
                                         input int row);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = ~m[row*4+c];
    return v;
  endfunction

  task automatic frame_eval();
    int  zeros = 0;
    int  cand  = 0;
    bit  cv;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!frm[r][c]) begin
          zeros++;
          cand = r * 4 + c;
        end
    cv = (zeros == 1);
    if (!held) begin
      if (cv && run_len > 0 && cand == run_key) run_len++;
      else if (cv) begin
        run_key = cand;
        run_len = 1;
      end else run_len = 0;
      if (run_len == DEB) begin
        held = 1;
        hkey = run_key;
        exp_valid = 1;
        exp_code = 4'(hkey);
        run_len = 0;
        miss = 0;
        hit = 0;
      end
    end else if (cv && cand == hkey) begin
      if (miss > 0) begin
        miss = 0;
        hit = 0;
      end else begin
        hit++;
`ifdef KEY_REPEAT_EN
        if (hit == REP) begin
          exp_valid = 1;
          hit = 0;
        end
`endif
      end
    end else begin
      miss++;
      if (miss == DEB) begin
        held = 0;
        miss = 0;
        run_len = 0;
      end
    end
    exp_held = held;
  endtask

  // Edge k after reset: slot end when k%SC==0, the sample holds the
  // columns seen two edges earlier; frame evaluated one edge later.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        k = 0;
        h1 = 4'hF;
        h2 = 4'hF;
        for (int i = 0; i < 4; i++) frm[i] = 4'hF;
        held = 0;
        hkey = 0;
        run_key = 0;
        run_len = 0;
        miss = 0;
        hit = 0;
        exp_valid = 0;
        exp_code = 0;
        exp_held = 0;
      end else begin
        colnow = cols_of(mask, (k / SC) % 4);
        k++;
        sample = h2;
        h2 = h1;
        h1 = colnow;
        exp_valid = 0;
        if (k % SC == 0) frm[((k - 1) / SC) % 4] = sample;
        if (k > 1 && (k - 1) % (4 * SC) == 0) frame_eval();
      end
      exp_row = ~(4'b0001 << ((k / SC) % 4));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("row", key_row, exp_row);
        chk("valid", key_valid, exp_valid);
        chk("code", key_code, exp_code);
        chk("held", key_held, exp_held);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(negedge clk);
    n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n = 0;
    chk("rst_row", key_row, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    chk("rst_code", key_code, 0);
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic wait_valid(input int limit, output int at,
                            output logic [3:0] code);
    at = -1;
    code = '0;
    while (n < limit) begin
      step();
      if (key_valid) begin
        at = n;
        code = key_code;
        return;
      end
    end
  endtask

  task automatic wait_held_low(input int limit, output int at);
    at = -1;
    while (n < limit) begin
      step();
      if (!key_held) begin
        at = n;
        return;
      end
    end
  endtask

  logic [3:0] row_tab [4];
  int         at;
  logic [3:0] code;

  initial begin
    row_tab[0] = 4'b1110;
    row_tab[1] = 4'b1101;
    row_tab[2] = 4'b1011;
    row_tab[3] = 4'b0111;

    // idle scan
    mask = '0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      chk("idle_row", key_row, row_tab[(n / SC) % 4]);
      chk("idle_valid", key_valid, 0);
    end

    // single held key, then release
    mask = 16'(1) << KEY_DOWN;
    do_reset();
    wait_valid(60, at, code);
    chk("k9_at", at, 49);
    chk("k9_code", code, KEY_DOWN);
    while (n < 60) step();
    mask = '0;
    wait_held_low(140, at);
    chk("k9_rel_at", at, 113);

    // short press: no event
    mask = 16'(1) << KEY_RIGHT;
    do_reset();
    while (n < 34) step();
    mask = '0;
    wait_valid(100, at, code);
    chk("k6_none", at, -1);
    chk("k6_held", key_held, 0);

    // two keys rejected, then one remains
    mask = (16'(1) << KEY_UP) | (16'(1) << KEY_LEFT);
    do_reset();
    wait_valid(80, at, code);
    chk("ghost_none", at, -1);
    mask = 16'(1) << KEY_UP;
    wait_valid(140, at, code);
    chk("k1_at", at, 129);
    chk("k1_code", code, KEY_UP);
    mask = '0;

    // reset during press debounce
    mask = 16'(1) << KEY_START;
    do_reset();
    while (n < 20) step();
    do_reset();
    wait_valid(60, at, code);
    chk("k0_at", at, 49);
    chk("k0_code", code, KEY_START);
    mask = '0;

    // long hold: repeat or single event
    mask = 16'(1) << KEY_LEFT;
    do_reset();
    wait_valid(60, at, code);
    chk("k4_at", at, 49);
    chk("k4_code", code, KEY_LEFT);
`ifdef KEY_REPEAT_EN
    wait_valid(140, at, code);
    chk("k4_rpt1", at, 129);
    chk("k4_rpt1_code", code, KEY_LEFT);
    wait_valid(220, at, code);
    chk("k4_rpt2", at, 209);
    chk("k4_rpt2_code", code, KEY_LEFT);
`else
    wait_valid(369, at, code);
    chk("k4_single", at, -1);
`endif
    mask = '0;
    do_reset();

    // random traffic
    for (int s = 0; s < 40; s++) begin
      int kind;
      int a;
      int b;
      kind = $urandom_range(0, 5);
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      case (kind)
        0: mask = '0;
        1, 2: mask = 16'(1) << a;
        3: mask = (16'(1) << a) | (16'(1) << b);
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) do_reset();
      repeat ($urandom_range(8, 160)) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
